// File: rtl/sdram_word_adapter.sv
// Splits 32-bit word requests into two 16-bit sdram commands (low then high halfword)
// and reassembles read halves into a single 32-bit completion; one request in flight.
module sdram_word_adapter #(
  parameter int SDRAM_AW = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [SDRAM_AW:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [31:0]         rsp_rdata,
  output logic                read,
  output logic                write,
  output logic [1:0]          wr_strb,
  output logic [SDRAM_AW-1:0] addr,
  input  logic                cmd_ready,
  output logic [15:0]         data_write,
  input  logic [15:0]         data_read,
  input  logic                data_read_val,
  output logic                err_unexpected
);

  typedef enum logic [2:0] {IDLE, CMD_LO, CMD_HI, WAIT_RD, RSP} state_t;

  state_t              state;
  logic [SDRAM_AW-2:0] word_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                write_q;
  logic [15:0]         rd_lo;
  logic [15:0]         rd_hi;
  logic [1:0]          beat_cnt;
  logic                accept;
  logic                rd_window;
  logic                unused_addr_lsb;

  assign accept          = req_valid & req_ready;
  assign rd_window       = ~write_q & ((state == CMD_LO) | (state == CMD_HI) | (state == WAIT_RD));
  assign unused_addr_lsb = ^req_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      read           <= 1'b0;
      write          <= 1'b0;
      wr_strb        <= '0;
      addr           <= '0;
      data_write     <= '0;
      err_unexpected <= 1'b0;
      word_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      write_q        <= 1'b0;
      rd_lo          <= '0;
      rd_hi          <= '0;
      beat_cnt       <= '0;
    end else begin
      // Beats are only legal while a read is between its first command and its completion.
      if (data_read_val) begin
        if (rd_window && beat_cnt != 2'd2) begin
          if (beat_cnt == 2'd0) rd_lo <= data_read;
          else                  rd_hi <= data_read;
          beat_cnt <= beat_cnt + 2'd1;
        end else begin
          err_unexpected <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            word_q    <= req_addr[SDRAM_AW:2];
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            write_q   <= req_write;
            beat_cnt  <= 2'd0;
            if (!req_write || req_wstrb[1:0] != 2'b00) begin
              state      <= CMD_LO;
              read       <= ~req_write;
              write      <= req_write;
              addr       <= {req_addr[SDRAM_AW:2], 1'b0};
              data_write <= req_wdata[15:0];
              wr_strb    <= req_wstrb[1:0];
            end else if (req_wstrb[3:2] != 2'b00) begin
              state      <= CMD_HI;
              write      <= 1'b1;
              addr       <= {req_addr[SDRAM_AW:2], 1'b1};
              data_write <= req_wdata[31:16];
              wr_strb    <= req_wstrb[3:2];
            end else begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_write <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end

        CMD_LO: begin
          if (cmd_ready) begin
            if (write_q && wstrb_q[3:2] == 2'b00) begin
              state      <= RSP;
              write      <= 1'b0;
              wr_strb    <= '0;
              data_write <= '0;
              rsp_valid  <= 1'b1;
              rsp_write  <= 1'b1;
              rsp_rdata  <= '0;
            end else begin
              state      <= CMD_HI;
              addr       <= {word_q, 1'b1};
              data_write <= wdata_q[31:16];
              wr_strb    <= wstrb_q[3:2];
            end
          end
        end

        CMD_HI: begin
          if (cmd_ready) begin
            read       <= 1'b0;
            write      <= 1'b0;
            wr_strb    <= '0;
            data_write <= '0;
            if (write_q) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_write <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= WAIT_RD;
            end
          end
        end

        WAIT_RD: begin
          // Uses the registered count, so a beat landing now completes next cycle.
          if (beat_cnt == 2'd2) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= {rd_hi, rd_lo};
          end
        end

        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_word_adapter.sv
// Bench for sdram_word_adapter: directed table, randomized traffic against a word-level model, reset corner.
module tb_sdram_word_adapter;
  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [31:0]   rsp_rdata;
  logic          read, write;
  logic [1:0]    wr_strb;
  logic [AW-1:0] addr;
  logic          cmd_ready;
  logic [15:0]   data_write, data_read;
  logic          data_read_val;
  logic          err_unexpected;

  always #5 clk = ~clk;

  sdram_word_adapter #(.SDRAM_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .read(read), .write(write), .wr_strb(wr_strb), .addr(addr), .cmd_ready(cmd_ready),
    .data_write(data_write), .data_read(data_read), .data_read_val(data_read_val),
    .err_unexpected(err_unexpected)
  );

  typedef struct { logic w; int a; logic [15:0] d; logic [1:0] s; } cmd_t;
  typedef struct { int a; int due; } pend_t;

  cmd_t        log_q[$];
  cmd_t        exp_q[$];
  pend_t       pend_q[$];
  logic [15:0] sd_mem[int];
  logic [15:0] ref_mem[int];
  int          checks = 0;
  int          errors = 0;
  int          stall_cmd = 0;
  int          rd_lat = 0;
  int          last_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    logic [31:0] v;
    v = a;
    return v[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Sdram stand-in: optional command stall, in-order read beats after rd_lat cycles.
  int          ncyc = 0;
  int          stall_left = -1;
  bit          stalled = 1'b0;
  logic [47:0] snap;
  always @(negedge clk) begin
    cmd_t  c;
    pend_t p;
    data_read_val = 1'b0;
    if (reset) begin
      cmd_ready  = 1'b0;
      stall_left = -1;
      stalled    = 1'b0;
    end else begin
      if (stalled)
        chk("cmd_stable_in_stall", {read, write, wr_strb, addr, data_write}, snap);
      stalled   = 1'b0;
      cmd_ready = 1'b0;
      if (read || write) begin
        if (stall_left < 0) stall_left = stall_cmd;
        if (stall_left > 0) begin
          stall_left--;
          stalled = 1'b1;
          snap = {read, write, wr_strb, addr, data_write};
        end else begin
          cmd_ready = 1'b1;
          stall_left = -1;
          c.w = write; c.a = int'(addr); c.d = data_write; c.s = wr_strb;
          log_q.push_back(c);
          if (write)
            sd_mem[c.a] = merge(sd_mem.exists(c.a) ? sd_mem[c.a] : pat(c.a), data_write, wr_strb);
          else begin
            p.a = c.a; p.due = ncyc + rd_lat;
            pend_q.push_back(p);
          end
        end
      end
      if (pend_q.size() > 0 && pend_q[0].due <= ncyc) begin
        data_read_val = 1'b1;
        data_read = sd_mem.exists(pend_q[0].a) ? sd_mem[pend_q[0].a] : pat(pend_q[0].a);
        void'(pend_q.pop_front());
      end
    end
    ncyc++;
  end

  // Word-level reference: which halfword commands a request must produce and what a read returns.
  task automatic model(input logic w, input logic [AW:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd);
    cmd_t c;
    int base;
    base = int'(a >> 2) * 2;
    exp_q.delete();
    rd = 32'h0;
    if (!w) begin
      c.w = 1'b0; c.d = 16'h0; c.s = 2'b00;
      c.a = base;     exp_q.push_back(c);
      c.a = base + 1; exp_q.push_back(c);
      rd[15:0]  = ref_mem.exists(base)     ? ref_mem[base]     : pat(base);
      rd[31:16] = ref_mem.exists(base + 1) ? ref_mem[base + 1] : pat(base + 1);
    end else begin
      if (ws[1:0] != 2'b00) begin
        c.w = 1'b1; c.a = base; c.d = wd[15:0]; c.s = ws[1:0];
        exp_q.push_back(c);
        ref_mem[base] = merge(ref_mem.exists(base) ? ref_mem[base] : pat(base), wd[15:0], ws[1:0]);
      end
      if (ws[3:2] != 2'b00) begin
        c.w = 1'b1; c.a = base + 1; c.d = wd[31:16]; c.s = ws[3:2];
        exp_q.push_back(c);
        ref_mem[base + 1] = merge(ref_mem.exists(base + 1) ? ref_mem[base + 1] : pat(base + 1), wd[31:16], ws[3:2]);
      end
    end
  endtask

  task automatic do_txn(input logic w, input logic [AW:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int cst, input int rlat, input int rhold,
                        input logic chk_rd, input logic [31:0] tab_rd, input int ncmd);
    logic [31:0] mrd, exp_rd, hold_rd;
    int n, nexp;
    stall_cmd = cst;
    rd_lat = rlat;
    log_q.delete();
    model(w, a, wd, ws, mrd);
    exp_rd = chk_rd ? tab_rd : mrd;
    nexp = (ncmd < 0) ? exp_q.size() : ncmd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = ws;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    last_lat = n;
    chk("rsp_valid_arrives", rsp_valid, 1);
    chk("req_ready_low_in_rsp", req_ready, 0);
    hold_rd = rsp_rdata;
    repeat (rhold) begin
      @(negedge clk);
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_rdata", rsp_rdata, hold_rd);
      chk("rsp_hold_req_ready", req_ready, 0);
    end
    chk("rsp_write", rsp_write, w);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clears", rsp_valid, 0);
    chk("cmd_count", log_q.size(), nexp);
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      chk("cmd_kind", log_q[i].w, exp_q[i].w);
      chk("cmd_addr", log_q[i].a, exp_q[i].a);
      if (exp_q[i].w) begin
        chk("cmd_data", log_q[i].d, exp_q[i].d);
        chk("cmd_strb", log_q[i].s, exp_q[i].s);
      end
    end
    chk("no_err_unexpected", err_unexpected, 0);
  endtask

  typedef struct {
    logic        w;
    logic [AW:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          cst, rlat, rhold;
    logic        chk_rd;
    logic [31:0] rd;
    int          ncmd;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rw;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0; cmd_ready = 1'b0; data_read = '0; data_read_val = 1'b0;

    //         w     addr      wdata          strb    cst rl rh chk  rdata         ncmd lat
    vecs[0] = '{1'b0, 27'h10,  32'h0,         4'h0,   0, 2, 0, 1'b1, 32'hDEADBEEF, 2,   0};
    vecs[1] = '{1'b1, 27'h100, 32'h12345678,  4'hF,   0, 0, 0, 1'b1, 32'h0,        2,   0};
    vecs[2] = '{1'b1, 27'h100, 32'hAABBCCDD,  4'b0100,0, 0, 0, 1'b1, 32'h0,        1,   0};
    vecs[3] = '{1'b1, 27'h104, 32'hFFFFFFFF,  4'b0000,0, 0, 0, 1'b1, 32'h0,        0,   1};
    vecs[4] = '{1'b0, 27'h100, 32'h0,         4'h0,   0, 0, 0, 1'b1, 32'h12BB5678, 2,   0};
    vecs[5] = '{1'b0, 27'h10,  32'h0,         4'h0,   5, 1, 0, 1'b1, 32'hDEADBEEF, 2,   0};
    vecs[6] = '{1'b0, 27'h100, 32'h0,         4'h0,   0, 3, 3, 1'b1, 32'h12BB5678, 2,   0};
    vecs[7] = '{1'b1, 27'h200, 32'hCAFE0042,  4'b0011,2, 0, 1, 1'b1, 32'h0,        1,   0};
    vecs[8] = '{1'b1, 27'h3FC, 32'h9876ABCD,  4'b1001,0, 0, 0, 1'b1, 32'h0,        2,   0};

    sd_mem[8] = 16'hBEEF; sd_mem[9] = 16'hDEAD;
    ref_mem[8] = 16'hBEEF; ref_mem[9] = 16'hDEAD;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_write, rsp_rdata, read, write, wr_strb, data_write, err_unexpected}, 0);
    chk("reset_addr", addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].ws, vecs[i].cst, vecs[i].rlat,
             vecs[i].rhold, vecs[i].chk_rd, vecs[i].rd, vecs[i].ncmd);
      if (vecs[i].lat != 0) chk("zero_strobe_latency", last_lat, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      logic [AW:0] ra;
      ra = '0;
      ra[7:2] = 6'($urandom_range(0, 63));
      ra[1:0] = 2'($urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 32'h0, -1);
    end

    // Reset while a read waits for its beats; the late beats must flag err_unexpected.
    stall_cmd = 0; rd_lat = 12; log_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h40; req_wstrb = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 20 && log_q.size() < 2; n++) @(negedge clk);
    chk("reset_test_cmds", log_q.size(), 2);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midop_reset_outputs", {req_ready, rsp_valid, rsp_write, rsp_rdata, read, write, wr_strb, data_write, err_unexpected}, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_err_clear", err_unexpected, 0);
    rw = 32'(pend_q.size());
    chk("beats_still_pending", rw != 0, 1);
    for (int n = 0; n < 30 && pend_q.size() > 0; n++) @(negedge clk);
    @(negedge clk);
    chk("stray_beat_sets_err", err_unexpected, 1);
    chk("stray_beat_no_rsp", rsp_valid, 0);
    chk("idle_after_stray", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
